// File: rtl/maxpool_frame_sequencer_pkg.sv
// Shared types and defaults for the max-pool frame sequencer.
// Holds the FSM state enum, default dimensions and a width helper.
package maxpool_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mp_state_t;

    localparam int MP_WIDTH    = 224;
    localparam int MP_HEIGHT   = 224;
    localparam int MP_CHANNELS = 64;
    localparam int MP_PIPE_LAT = 2;

    // Index width for n entries, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/maxpool_frame_sequencer_if.sv
// Handshake and strobe bundle between the pixel source and the pooling datapath.
// master: drives start/valid_in. slave: the sequencer, drives all strobes.
interface maxpool_frame_sequencer_if #(
    parameter int CW = 8,
    parameter int KW = 6
);
    logic          start;
    logic          valid_in;
    logic          busy;
    logic          lb_wr_en;
    logic          lb_rd_en;
    logic [CW-1:0] lb_addr;
    logic          win_en;
    logic          valid_out;
    logic [KW-1:0] ch_idx;
    logic          frame_done;
    logic          overrun;

    modport master (
        output start, valid_in,
        input  busy, lb_wr_en, lb_rd_en, lb_addr, win_en,
        input  valid_out, ch_idx, frame_done, overrun
    );

    modport slave (
        input  start, valid_in,
        output busy, lb_wr_en, lb_rd_en, lb_addr, win_en,
        output valid_out, ch_idx, frame_done, overrun
    );
endinterface

// File: rtl/maxpool_frame_sequencer_pool_valid_delay.sv
// PIPE_LAT-stage 1-bit shift register with async active-high reset.
// Ports: clk, rst, d_i (input bit), q_o (d_i delayed by PIPE_LAT cycles).
module pool_valid_delay #(
    parameter int PIPE_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [PIPE_LAT-1:0] sr_q;
    logic [PIPE_LAT-1:0] sr_d;

    generate
        if (PIPE_LAT == 1) begin : g_one
            assign sr_d = d_i;
        end else begin : g_many
            assign sr_d = {sr_q[PIPE_LAT-2:0], d_i};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q[PIPE_LAT-1];
endmodule

// File: rtl/maxpool_frame_sequencer.sv
// Frame sequencer for 2x2 stride-2 max pooling: tracks col/row/channel,
// issues line-buffer strobes and window enables, and delays them to valid_out.
// Ports: clk, rst (async, active high), bus (slave modport of the bundle).
module maxpool_frame_sequencer
    import maxpool_pkg::*;
#(
    parameter int WIDTH    = MP_WIDTH,
    parameter int HEIGHT   = MP_HEIGHT,
    parameter int CHANNELS = MP_CHANNELS,
    parameter int PIPE_LAT = MP_PIPE_LAT
) (
    input  logic                      clk,
    input  logic                      rst,
    maxpool_frame_sequencer_if.slave  bus
);
    localparam int CW = clog2_min1(WIDTH);
    localparam int RW = clog2_min1(HEIGHT);
    localparam int KW = clog2_min1(CHANNELS);

    mp_state_t     state_q;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [KW-1:0] ch_q, ch_d;
    logic          busy_q;
    logic          done_q;

    logic beat;
    logic col_last, row_last, ch_last;
    logic last_beat;
    logic win;
    logic drain_tap;

    assign beat      = bus.valid_in & (state_q == RUN);
    assign col_last  = (col_q == CW'(WIDTH - 1));
    assign row_last  = (row_q == RW'(HEIGHT - 1));
    assign ch_last   = (ch_q == KW'(CHANNELS - 1));
    assign last_beat = beat & col_last & row_last & ch_last;
    assign win       = beat & row_q[0] & col_q[0];

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        ch_d  = ch_q;
        if (state_q == IDLE && bus.start) begin
            col_d = '0;
            row_d = '0;
            ch_d  = '0;
        end else if (beat) begin
            col_d = col_last ? '0 : col_q + CW'(1);
            if (col_last) begin
                row_d = row_last ? '0 : row_q + RW'(1);
                if (row_last) begin
                    ch_d = ch_last ? '0 : ch_q + KW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            ch_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            ch_q  <= ch_d;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_beat) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // drain_tap is last_beat seen PIPE_LAT cycles later
                    if (drain_tap) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    pool_valid_delay #(.PIPE_LAT(PIPE_LAT)) u_vout_dly (
        .clk (clk),
        .rst (rst),
        .d_i (win),
        .q_o (bus.valid_out)
    );

    pool_valid_delay #(.PIPE_LAT(PIPE_LAT)) u_drain_dly (
        .clk (clk),
        .rst (rst),
        .d_i (last_beat),
        .q_o (drain_tap)
    );

    assign bus.lb_wr_en   = beat & ~row_q[0];
    assign bus.lb_rd_en   = beat & row_q[0];
    assign bus.win_en     = win;
    assign bus.lb_addr    = col_q;
    assign bus.ch_idx     = ch_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.overrun    = bus.valid_in & (state_q != RUN);
endmodule

// File: tb/tb_maxpool_frame_sequencer.sv
// Scoreboard bench for maxpool_frame_sequencer: 4x4x2 and 5x5x1 instances.
// Driver pushes expected strobes/valid_out/done/overrun; monitor pops at negedge.
module tb_maxpool_frame_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maxpool_frame_sequencer_if #(.CW(2), .KW(1)) b4 ();
    maxpool_frame_sequencer_if #(.CW(3), .KW(1)) b5 ();

    maxpool_frame_sequencer #(
        .WIDTH(4), .HEIGHT(4), .CHANNELS(2), .PIPE_LAT(2)
    ) u4 (
        .clk (clk),
        .rst (rst),
        .bus (b4.slave)
    );

    maxpool_frame_sequencer #(
        .WIDTH(5), .HEIGHT(5), .CHANNELS(1), .PIPE_LAT(2)
    ) u5 (
        .clk (clk),
        .rst (rst),
        .bus (b5.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_vout = 0;
    int n_win5 = 0;
    int m_col = 0;
    int m_row = 0;
    int m_ch = 0;

    logic [5:0] sq[$];
    int vq[$];
    int dq[$];
    int oq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops expectations whenever the DUT presents an output
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (b4.lb_wr_en | b4.lb_rd_en | b4.win_en) begin
                if (sq.size() == 0)
                    chk("strobe_unexpected", sq.size(), 1);
                else
                    chk("strobe",
                        int'({b4.lb_wr_en, b4.lb_rd_en, b4.win_en,
                              b4.lb_addr, b4.ch_idx}),
                        int'(sq.pop_front()));
            end
            if (b4.valid_out) begin
                n_vout++;
                if (vq.size() == 0) chk("vout_unexpected", cyc, -1);
                else chk("vout_cycle", cyc, vq.pop_front());
            end
            if (b4.frame_done) begin
                if (dq.size() == 0) chk("done_unexpected", cyc, -1);
                else chk("done_cycle", cyc, dq.pop_front());
            end
            if (b4.overrun) begin
                if (oq.size() == 0) chk("ovr_unexpected", cyc, -1);
                else chk("ovr_cycle", cyc, oq.pop_front());
            end
            if (b5.win_en) begin
                n_win5++;
                chk("w5_col_odd", int'(b5.lb_addr[0]), 1);
                chk("w5_col_lt4", int'(b5.lb_addr < 3'd4), 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat();
        logic [5:0] v;
        v[5]   = (m_row % 2 == 0);
        v[4]   = (m_row % 2 == 1);
        v[3]   = (m_row % 2 == 1) && (m_col % 2 == 1);
        v[2:1] = m_col[1:0];
        v[0]   = m_ch[0];
        sq.push_back(v);
        if (v[3]) vq.push_back(cyc + 2);
        if (m_col == 3 && m_row == 3 && m_ch == 1) dq.push_back(cyc + 3);
        m_col++;
        if (m_col == 4) begin
            m_col = 0;
            m_row++;
            if (m_row == 4) begin
                m_row = 0;
                m_ch = (m_ch + 1) % 2;
            end
        end
    endtask

    task automatic beat();
        b4.valid_in = 1'b1;
        push_beat();
        tick();
        b4.valid_in = 1'b0;
    endtask

    task automatic stray();
        b4.valid_in = 1'b1;
        oq.push_back(cyc);
        tick();
        b4.valid_in = 1'b0;
    endtask

    task automatic stray_idle();
        b4.valid_in = 1'b1;
        oq.push_back(cyc);
        @(negedge clk);
        chk("idle_addr", int'(b4.lb_addr), m_col);
        chk("idle_ch", int'(b4.ch_idx), m_ch);
        tick();
        b4.valid_in = 1'b0;
    endtask

    task automatic start4();
        b4.start = 1'b1;
        m_col = 0;
        m_row = 0;
        m_ch = 0;
        tick();
        b4.start = 1'b0;
        chk("busy_after_start", int'(b4.busy), 1);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("gap_addr", int'(b4.lb_addr), m_col);
            tick();
        end
    endtask

    int gtab[8] = '{0, 1, 3, 2, 0, 2, 1, 3};
    int n0;

    initial begin
        rst = 1'b1;
        b4.start = 1'b0;
        b4.valid_in = 1'b0;
        b5.start = 1'b0;
        b5.valid_in = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_state",
            int'({b4.busy, b4.lb_wr_en, b4.lb_rd_en, b4.win_en,
                  b4.valid_out, b4.frame_done, b4.overrun,
                  b4.lb_addr, b4.ch_idx}), 0);
        tick();

        // valid_in while idle
        stray_idle();
        tick();

        // Frame A: continuous, then a beat during DRAIN
        n0 = n_vout;
        start4();
        for (int i = 0; i < 32; i++) beat();
        stray();
        repeat (5) tick();
        chk("frameA_vouts", n_vout - n0, 8);
        chk("frameA_busy_low", int'(b4.busy), 0);

        // Counters wrapped back to zero and hold in IDLE
        stray_idle();
        tick();

        // Frame B: start with valid_in in same cycle, gaps, mid-frame start
        n0 = n_vout;
        b4.start = 1'b1;
        b4.valid_in = 1'b1;
        oq.push_back(cyc);
        m_col = 0;
        m_row = 0;
        m_ch = 0;
        tick();
        b4.start = 1'b0;
        b4.valid_in = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 12) b4.start = 1'b1;
            beat();
            b4.start = 1'b0;
            gap(gtab[i % 8]);
        end
        repeat (5) tick();
        chk("frameB_vouts", n_vout - n0, 8);

        // 5x5x1 frame: odd dimensions floored
        b5.start = 1'b1;
        tick();
        b5.start = 1'b0;
        b5.valid_in = 1'b1;
        repeat (25) tick();
        b5.valid_in = 1'b0;
        repeat (5) tick();
        chk("w5_count", n_win5, 4);

        // Reset one cycle after a window beat
        start4();
        for (int i = 0; i < 8; i++) beat();
        rst = 1'b1;
        sq.delete();
        vq.delete();
        dq.delete();
        @(negedge clk);
        chk("rst_outputs",
            int'({b4.busy, b4.lb_wr_en, b4.lb_rd_en, b4.win_en,
                  b4.valid_out, b4.frame_done, b4.overrun,
                  b4.lb_addr, b4.ch_idx}), 0);
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("rst_busy_low", int'(b4.busy), 0);

        // Full frame after reset
        n0 = n_vout;
        start4();
        for (int i = 0; i < 32; i++) beat();
        repeat (5) tick();
        chk("frameC_vouts", n_vout - n0, 8);

        chk("strobe_q_empty", sq.size(), 0);
        chk("vout_q_empty", vq.size(), 0);
        chk("done_q_empty", dq.size(), 0);
        chk("ovr_q_empty", oq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
